// File: rtl/reservoir_pkg.sv
// Shared types and helpers for the reservoir weight generator.
// Sparse thresholding is enabled by defining WEIGHT_GEN_SPARSE_EN.
package reservoir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam int          WEIGHT_W_DEF = 8;
    localparam logic [7:0]  DENSITY_DEF  = 8'h80;

    // Sign-extend raw[w-1:0] and pull the most-negative code in by one
    // so the weight range is symmetric around zero.
    function automatic logic signed [15:0] sat_weight(
        input logic [15:0] raw,
        input int unsigned w
    );
        logic signed [15:0] v;
        logic signed [15:0] vmin;
        v    = $signed(raw << (16 - w)) >>> (16 - w);
        vmin = $signed(16'h8000) >>> (16 - w);
        if (v == vmin) begin
            v = vmin + 16'sd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/reservoir_weight_gen_weight_map.sv
// Random word to signed weight mapping with non-zero flag.
// Sparse zeroing is compiled in only with WEIGHT_GEN_SPARSE_EN.
module weight_map
    import reservoir_pkg::*;
#(
    parameter int         WEIGHT_W = WEIGHT_W_DEF,
    parameter logic [7:0] DENSITY  = DENSITY_DEF
) (
    input  logic [15:0]                rnd_data,
    output logic signed [WEIGHT_W-1:0] weight,
    output logic                       nonzero
);

    logic signed [15:0] sw;
    logic               unused_ok;

    always_comb begin
        sw     = sat_weight(rnd_data, WEIGHT_W);
        weight = sw[WEIGHT_W-1:0];
`ifdef WEIGHT_GEN_SPARSE_EN
        if (rnd_data[15:8] >= DENSITY) begin
            weight = '0;
        end
`else
        weight = sw[WEIGHT_W-1:0];
`endif
        nonzero = |weight;
    end

    // Upper word bits and the threshold are dead in some configurations.
    assign unused_ok = ^{rnd_data, sw, DENSITY};

endmodule

// File: rtl/reservoir_weight_gen.sv
// Fills the reservoir weight RAM from the LFSR word stream.
// Define WEIGHT_GEN_SPARSE_EN to zero words at or above DENSITY.
module reservoir_weight_gen
    import reservoir_pkg::*;
#(
    parameter int         N_WEIGHTS = 256,
    parameter int         ADDR_W    = 8,
    parameter int         WEIGHT_W  = WEIGHT_W_DEF,
    parameter logic [7:0] DENSITY   = DENSITY_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       rnd_valid,
    input  logic [15:0]                rnd_data,
    output logic                       rnd_ready,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic signed [WEIGHT_W-1:0] wr_data,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W:0]            nz_count
);

    state_t                     state;
    state_t                     state_nx;
    logic [ADDR_W-1:0]          cnt;
    logic                       hs;
    logic                       last;
    logic signed [WEIGHT_W-1:0] weight;
    logic                       nonzero;

    weight_map #(
        .WEIGHT_W (WEIGHT_W),
        .DENSITY  (DENSITY)
    ) u_map (
        .rnd_data (rnd_data),
        .weight   (weight),
        .nonzero  (nonzero)
    );

    assign hs   = rnd_valid & rnd_ready;
    assign last = (cnt == ADDR_W'(N_WEIGHTS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_FILL;
            ST_FILL: if (hs && last) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rnd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_FILL: begin
                rnd_ready = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            nz_count <= '0;
        end else begin
            wr_en <= hs;
            if (state == ST_IDLE && start) begin
                cnt      <= '0;
                nz_count <= '0;
            end
            if (hs) begin
                wr_addr <= cnt;
                wr_data <= weight;
                cnt     <= cnt + ADDR_W'(1);
                if (nonzero) begin
                    nz_count <= nz_count + (ADDR_W + 1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reservoir_weight_gen.sv
// Directed-vector bench for reservoir_weight_gen (N=4, W=8).
// Sparse expectations follow WEIGHT_GEN_SPARSE_EN.
module tb_reservoir_weight_gen;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int W  = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                rnd_valid = 1'b0;
    logic [15:0]         rnd_data = '0;
    logic                rnd_ready;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic signed [W-1:0] wr_data;
    logic                busy;
    logic                done;
    logic [AW:0]         nz_count;

    int vectors = 0;
    int errors  = 0;

    reservoir_weight_gen #(
        .N_WEIGHTS (N),
        .ADDR_W    (AW),
        .WEIGHT_W  (W),
        .DENSITY   (8'h80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_ready (rnd_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .nz_count  (nz_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst = 1'b1;
        rnd_valid = 1'b1;
        rnd_data = 16'h0005;
        repeat (3) tick();
        obs = {rnd_ready, wr_en, 2'(wr_addr), 8'(wr_data),
               busy, done, 3'(nz_count)};
        vectors++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0000", obs);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (wr_en !== 1'b0 || rnd_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_valid: wr_en=%b ready=%b busy=%b want 0",
                     wr_en, rnd_ready, busy);
        end
        rnd_valid = 1'b0;
    endtask

    task automatic test_fill();
        logic [15:0] w [4] = '{16'h0005, 16'h00FF, 16'h0080, 16'h0000};
        logic [7:0]  e [4] = '{8'h05, 8'hFF, 8'h81, 8'h00};
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || rnd_ready !== 1'b1 || nz_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_start: busy=%b ready=%b nz=%0d want 1 1 0",
                     busy, rnd_ready, nz_count);
        end
        for (int i = 0; i < 4; i++) begin
            rnd_valid = 1'b1;
            rnd_data = w[i];
            tick();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== e[i]
                || done !== (i == 3)) begin
                errors++;
                $display("FAIL fill_write%0d: en=%b a=%0d d=%h done=%b want 1 %0d %h %b",
                         i, wr_en, wr_addr, wr_data, done, i, e[i], i == 3);
            end
        end
        vectors++;
        if (nz_count !== 3'd3) begin
            errors++;
            $display("FAIL fill_nz: got %0d want 3", nz_count);
        end
        rnd_valid = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0
            || nz_count !== 3'd3) begin
            errors++;
            $display("FAIL fill_end: busy=%b done=%b en=%b nz=%0d want 0 0 0 3",
                     busy, done, wr_en, nz_count);
        end
    endtask

    task automatic test_sparsity();
        logic [15:0] w [4] = '{16'h8005, 16'h7F05, 16'h8080, 16'h0001};
`ifdef WEIGHT_GEN_SPARSE_EN
        logic [7:0]  e [4] = '{8'h00, 8'h05, 8'h00, 8'h01};
        logic [2:0]  enz = 3'd2;
`else
        logic [7:0]  e [4] = '{8'h05, 8'h05, 8'h81, 8'h01};
        logic [2:0]  enz = 3'd4;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rnd_valid = 1'b1;
            rnd_data = w[i];
            tick();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== e[i]) begin
                errors++;
                $display("FAIL sparse_write%0d: en=%b a=%0d d=%h want 1 %0d %h",
                         i, wr_en, wr_addr, wr_data, i, e[i]);
            end
        end
        vectors++;
        if (done !== 1'b1 || nz_count !== enz) begin
            errors++;
            $display("FAIL sparse_nz: done=%b nz=%0d want 1 %0d",
                     done, nz_count, enz);
        end
        rnd_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rnd_valid = pat[i];
            rnd_data = 16'(n + 1);
            tick();
            vectors++;
            if (wr_en !== pat[i] || (pat[i] && (wr_addr !== AW'(n)
                || wr_data !== 8'(n + 1)))) begin
                errors++;
                $display("FAIL stall_cyc%0d: en=%b a=%0d d=%h want %b %0d %h",
                         i, wr_en, wr_addr, wr_data, pat[i], n, 8'(n + 1));
            end
            if (pat[i]) n++;
        end
        vectors++;
        if (done !== 1'b1 || nz_count !== 3'd4) begin
            errors++;
            $display("FAIL stall_done: done=%b nz=%0d want 1 4", done, nz_count);
        end
        rnd_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] w [4] = '{16'h0000, 16'h0003, 16'h0000, 16'h0000};
        int dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        rnd_valid = 1'b1;
        rnd_data = 16'h0001;
        tick();
        rnd_data = 16'h0002;
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || rnd_ready !== 1'b0 || nz_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: en=%b busy=%b done=%b ready=%b nz=%0d want 0",
                     wr_en, busy, done, rnd_ready, nz_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
        end
        vectors++;
        if (dones != 0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: dones=%0d en=%b want 0 0", dones, wr_en);
        end
        start = 1'b1;
        rnd_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rnd_valid = 1'b1;
            rnd_data = w[i];
            tick();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr !== AW'(i)) begin
                errors++;
                $display("FAIL refill_addr%0d: en=%b a=%0d want 1 %0d",
                         i, wr_en, wr_addr, i);
            end
        end
        vectors++;
        if (done !== 1'b1 || nz_count !== 3'd1) begin
            errors++;
            $display("FAIL refill_nz: done=%b nz=%0d want 1 1", done, nz_count);
        end
        rnd_valid = 1'b0;
        tick();
    endtask

    task automatic test_start_ignored();
        int writes = 0;
        int dones = 0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            rnd_valid = 1'b1;
            rnd_data = 16'h0011;
            tick();
            if (wr_en) writes++;
            if (done) dones++;
        end
        start = 1'b1;
        rnd_valid = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || rnd_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b ready=%b want 0 0",
                     busy, rnd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_en) writes++;
            if (done) dones++;
            tick();
        end
        rnd_valid = 1'b0;
        vectors++;
        if (writes != N || dones != 1) begin
            errors++;
            $display("FAIL start_ignored: writes=%0d dones=%0d want %0d 1",
                     writes, dones, N);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_sparsity();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reservoir_weight_gen.md
# reservoir_weight_gen

Converts the stream of 16-bit pseudo-random words from the upstream LFSR stage into signed, optionally sparse reservoir weights and writes them into the reservoir weight RAM. It sits directly downstream of the LFSR. On `start` it fills addresses 0..N_WEIGHTS-1 with one weight per accepted random word, then pulses `done` and reports the non-zero weight count.

## Interface
- `N_WEIGHTS`, 256: number of weights written per fill (≥1)
- `ADDR_W`, 8: address width; must satisfy 2^ADDR_W ≥ N_WEIGHTS
- `WEIGHT_W`, 8: signed weight width (2..16)
- `DENSITY`, 8'h80: keep threshold for sparse mode; a word is kept when rnd_data[15:8] < DENSITY
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a fill; sampled only in IDLE
- `rnd_valid` in 1: random word valid
- `rnd_data` in 16: random word from LFSR
- `rnd_ready` out 1: block accepts a word this cycle
- `wr_en` out 1: weight RAM write strobe
- `wr_addr` out ADDR_W: write address
- `wr_data` out WEIGHT_W: signed weight
- `busy` out 1: fill in progress (FILL or DONE)
- `done` out 1: one-cycle completion pulse
- `nz_count` out ADDR_W+1: number of non-zero weights written in the last fill

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: `rnd_ready`=0. When `start`=1, go to FILL, clear the address counter and `nz_count`.
- FILL: `rnd_ready`=1. A handshake is `rnd_valid & rnd_ready`. On each handshake:
  - register `wr_en`=1, `wr_addr`=counter, `wr_data`=map(rnd_data);
  - increment the counter;
  - increment `nz_count` if the mapped weight ≠ 0.
- After the handshake at counter = N_WEIGHTS-1, go to DONE.
- DONE: one cycle, `done`=1, `rnd_ready`=0, then return to IDLE.
- Mapping: raw = rnd_data[WEIGHT_W-1:0] as two's complement. The most-negative value saturates to -(2^(WEIGHT_W-1)-1), which keeps weights symmetric. In sparse mode, raw is replaced by 0 when rnd_data[15:8] ≥ DENSITY.
- `start` in FILL or DONE is ignored. `rnd_valid` outside FILL is ignored, so no word is consumed.
- `nz_count` holds its value after `done` until the next `start`.

## Timing
- Reset values: `rnd_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `nz_count`=0. State is IDLE.
- `start` at cycle t → state FILL and `busy`=1 at t+1. `rnd_ready`=1 from t+1.
- Handshake at cycle t → `wr_en`/`wr_addr`/`wr_data` valid at t+1, for exactly one cycle unless another handshake occurs at t+1.
- Throughput is one weight per cycle with `rnd_valid` held high. A fill takes N_WEIGHTS+2 cycles from `start`.
- Final handshake at t → final write, `done`=1 and final `nz_count` all at t+1. `busy`=0 and state IDLE at t+2.
- `rst` mid-fill: next cycle is IDLE with all outputs at reset values, no `done`, and a partial RAM image left in place. The next `start` refills from address 0.
- N_WEIGHTS=1: a single handshake leads directly to DONE.

## Configuration
- `WEIGHT_GEN_SPARSE_EN` defined: DENSITY thresholding is applied as described.
- Not defined: every weight is the saturated raw value (dense); DENSITY is unused. `nz_count` still counts non-zero raw values.

## Structure
- Shared package `reservoir_pkg` holds:
  - FSM state enum;
  - default WEIGHT_W and DENSITY constants;
  - a `sat_weight` function (raw → saturated signed weight).
- One sub-module, `weight_map`: combinational rnd_data → weight plus a non-zero flag. It contains the sparse logic under the macro.

## Test plan
- Reset: hold `rst` 3 cycles. All outputs are 0 and `rnd_ready`=0 even with `rnd_valid`=1.
- Fill (N=4, W=8, sparse, DENSITY=8'h80), words 16'h0005, 16'h00FF, 16'h0080, 16'h0000 back-to-back:
  - writes (0,5), (1,-1), (2,-127), (3,0);
  - `done` with the addr-3 write;
  - `nz_count`=3.
- Sparsity: word 16'h8005 → written 0. Word 16'h7F05 → written 5. Without the macro, both → 5.
- Stall: `rnd_valid` toggled 1,0,0,1,1,0,1 → `wr_en` only one cycle after each handshake, addresses contiguous 0..3, no write while `rnd_valid`=0.
- Reset after 2 writes:
  - `wr_en`/`busy` drop the next cycle and no `done` fires;
  - a new `start` writes from addr 0 with `nz_count` restarted.
- `start` pulsed during FILL and during the DONE cycle → ignored. Exactly N writes and one `done` pulse.
